oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine for the CPU side of the NES architecture. Snoops CPU writes to $4014, stalls the CPU, and copies one 256-byte CPU page to the PPU OAM data port ($2004) as read/write pairs on the CPU bus. Sits between the CPU core and the CPU bus selection logic: when `DMA_ACTIVE` is high, the top level routes `DMA_ADDR`/`DMA_RW_n`/`DMA_DATA_OUT` onto the CPU bus in place of the CPU outputs.

## Interface
- `TRIGGER_ADDR`, 16'h4014: CPU write address that starts a transfer.
- `OAM_ADDR`, 16'h2004: destination address for every DMA write.
- `CLK` in 1: CPU clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `ENABLE` in 1: clock enable, shared with the CPU; when low, all state, including parity, holds.
- `CPU_ADDR` in 16: CPU address output, snooped.
- `CPU_DATA_OUT` in 8: CPU write data, snooped; supplies the source page.
- `CPU_RW_n` in 1: CPU read (1) / write (0).
- `DMA_DATA_IN` in 8: CPU data bus read value during DMA reads.
- `CPU_RDY` out 1: 0 freezes the CPU core.
- `DMA_ACTIVE` out 1: 1 means the DMA owns the CPU bus.
- `DMA_ADDR` out 16: bus address while active.
- `DMA_RW_n` out 1: bus direction while active.
- `DMA_DATA_OUT` out 8: bus write data while active.

## Operation
- Registers:
  - `state` ∈ {IDLE, HALT, ALIGN, READ, WRITE}
  - `page` [7:0]
  - `cnt` [7:0]
  - `latch` [7:0]
  - `parity` [0]: toggles every enabled cycle; 0 = even ("get") cycle.
- All outputs decode from registered state. No combinational path from inputs to outputs.
- IDLE:
  - Outputs: `CPU_RDY`=1, `DMA_ACTIVE`=0, `DMA_ADDR`=16'h0000, `DMA_RW_n`=1, `DMA_DATA_OUT`=8'h00.
  - Trigger: if `CPU_RW_n`=0 and `CPU_ADDR`==`TRIGGER_ADDR` on an enabled cycle, then `page`<=`CPU_DATA_OUT`, `cnt`<=0, next state HALT.
- HALT (always exactly 1 cycle):
  - Outputs: `CPU_RDY`=0, `DMA_ACTIVE`=1, `DMA_ADDR`={`page`,8'h00}, `DMA_RW_n`=1 (dummy read; data ignored).
  - Next state: READ if the following cycle is even; otherwise ALIGN.
- ALIGN (0 or 1 cycle):
  - Outputs: same as HALT.
  - Next state: READ.
- READ (always even cycle):
  - Outputs: `DMA_ADDR`={`page`,`cnt`}, `DMA_RW_n`=1.
  - `latch`<=`DMA_DATA_IN` at the closing edge.
  - Next state: WRITE.
- WRITE (always odd cycle):
  - Outputs: `DMA_ADDR`=`OAM_ADDR`, `DMA_RW_n`=0, `DMA_DATA_OUT`=`latch`.
  - `cnt`<=`cnt`+1, 8-bit wrap.
  - Next state: IDLE if `cnt`==8'hFF, else READ.
- In every state except IDLE: `CPU_RDY`=0 and `DMA_ACTIVE`=1.
- Triggers are evaluated only in IDLE. The DMA's own $2004 writes, and any write snooped while busy, are ignored.
- Page arithmetic: `cnt` never carries into `page`. Page $FF reads $FF00–$FFFF.
- Reset mid-transfer: immediate return to IDLE with all registers 0 and IDLE outputs. The partial OAM contents are left as written.

## Timing
- Trigger write in cycle N (parity p). HALT is cycle N+1.
  - p=0: first READ at N+2; total stall 513 enabled cycles.
  - p=1: ALIGN at N+2, first READ at N+3; total stall 514 enabled cycles.
- `CPU_RDY` falls 1 cycle after the trigger write. It rises on the cycle after the final WRITE; the CPU resumes there.
- Each byte takes 2 enabled cycles. `DMA_DATA_IN` must be valid at the rising `CLK` edge ending READ. MEM_CLK-based RAM/ROM satisfy this.
- `ENABLE`=0 inserts hold cycles. These do not count toward 513/514 and do not flip `parity`.
- Reset values:
  - Outputs: `CPU_RDY`=1, `DMA_ACTIVE`=0, `DMA_ADDR`=0, `DMA_RW_n`=1, `DMA_DATA_OUT`=0.
  - Registers: `parity`=0, `state`=IDLE.

## Test plan
- Even-aligned transfer:
  - Stimulus: RAM $0200+i = i^8'h5A; write $02 to $4014 on an even cycle.
  - Response: exactly 513 cycles with `CPU_RDY`=0. 256 writes to $2004 carry data 5A,5B,58,…,A5 in order. Then `CPU_RDY`=1.
- Odd-aligned transfer:
  - Stimulus: same as above, but the trigger lands on an odd cycle.
  - Response: one ALIGN cycle; 514 stall cycles; identical data.
- Page wrap:
  - Stimulus: trigger with $FF.
  - Response: reads hit $FF00–$FFFF only; the final read address is $FFFF; `cnt` ends at 0.
- Non-trigger traffic:
  - Stimulus: CPU reads $4014; CPU writes $4015 and $2004.
  - Response: `CPU_RDY` stays 1 and `DMA_ACTIVE` stays 0.
- ENABLE gaps:
  - Stimulus: deassert `ENABLE` for 3 cycles in the middle of READ 100.
  - Response: state, `cnt` and `parity` hold. Transfer completes with the correct data and 513/514 enabled stall cycles.
- Reset mid-operation:
  - Stimulus: assert `RESET` asynchronously at byte 37.
  - Response: outputs return to reset values before the next edge. A new trigger with $03 then performs a full 256-byte copy from $0300.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: NES OAM DMA engine, snoops $4014 writes, stalls the CPU and copies one page to $2004.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  input  logic [7:0]  DMA_DATA_IN,
  output logic        CPU_RDY,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RW_n,
  output logic [7:0]  DMA_DATA_OUT
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [7:0] page_q, page_d, cnt_q, cnt_d, latch_q, latch_d;
  logic parity_q, parity_d;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      page_q <= '0;
      cnt_q <= '0;
      latch_q <= '0;
      parity_q <= 1'b0;
    end else if (ENABLE) begin
      state_q <= state_d;
      page_q <= page_d;
      cnt_q <= cnt_d;
      latch_q <= latch_d;
      parity_q <= parity_d;
    end
  end
  always_comb begin
    state_d = state_q;
    page_d = page_q;
    cnt_d = cnt_q;
    latch_d = latch_q;
    parity_d = ~parity_q;
    case (state_q)
      IDLE: if (!CPU_RW_n && CPU_ADDR == TRIGGER_ADDR) begin
        page_d = CPU_DATA_OUT;
        cnt_d = '0;
        state_d = HALT;
      end
      HALT: state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        latch_d = DMA_DATA_IN;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    DMA_ACTIVE = state_q != IDLE;
    CPU_RDY = state_q == IDLE;
    DMA_RW_n = state_q != WRITE;
    DMA_DATA_OUT = (state_q == WRITE) ? latch_q : 8'h00;
    DMA_ADDR = (state_q == READ) ? {page_q, cnt_q} :
               (state_q == WRITE) ? OAM_ADDR :
               (state_q == HALT || state_q == ALIGN) ? {page_q, 8'h00} : 16'h0000;
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma against a byte-addressed bus memory.
module tb_oam_dma;
  logic CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b1, CPU_RW_n = 1'b1;
  logic [15:0] CPU_ADDR = '0;
  logic [7:0] CPU_DATA_OUT = '0;
  logic [7:0] DMA_DATA_IN;
  logic CPU_RDY, DMA_ACTIVE, DMA_RW_n;
  logic [15:0] DMA_ADDR;
  logic [7:0] DMA_DATA_OUT;
  logic [7:0] mem [0:65535];
  int checks = 0, failures = 0;
  logic ep = 1'b0;
  oam_dma dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n), .DMA_DATA_IN(DMA_DATA_IN),
    .CPU_RDY(CPU_RDY), .DMA_ACTIVE(DMA_ACTIVE), .DMA_ADDR(DMA_ADDR),
    .DMA_RW_n(DMA_RW_n), .DMA_DATA_OUT(DMA_DATA_OUT)
  );
  always #5 CLK = ~CLK;
  assign DMA_DATA_IN = mem[DMA_ADDR];
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    logic en;
    en = ENABLE;
    @(posedge CLK);
    #1;
    if (en) ep = ~ep;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(CPU_RDY), 32'd1);
    chk({tag, "_act"}, 32'(DMA_ACTIVE), 32'd0);
    chk({tag, "_addr"}, 32'(DMA_ADDR), 32'h0000);
    chk({tag, "_rw"}, 32'(DMA_RW_n), 32'd1);
    chk({tag, "_dout"}, 32'(DMA_DATA_OUT), 32'h00);
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    ep = 1'b0;
  endtask
  // gap: byte index whose READ gets 3 disabled cycles; rst_at: byte index that triggers an async reset
  task automatic xfer(input string tag, input logic [7:0] pg, input logic par,
                      input int exp_stall, input int gap, input int rst_at);
    int stall, wr, bound;
    logic [15:0] last_rd;
    logic [15:0] hold;
    bool_gap_done: begin end
    if (ep !== par) step();
    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = pg;
    step();
    CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h00;
    stall = 0; wr = 0; bound = 0; last_rd = 16'h0000;
    chk({tag, "_halt_addr"}, 32'(DMA_ADDR), {16'h0, pg, 8'h00});
    while (!CPU_RDY && bound < 2000) begin
      bound++;
      stall++;
      if (!DMA_RW_n) begin
        chk({tag, "_wr_addr"}, 32'(DMA_ADDR), 32'h2004);
        chk({tag, "_rd_addr"}, 32'(last_rd), {16'h0, pg, 8'(wr)});
        chk({tag, "_wr_data"}, 32'(DMA_DATA_OUT), 32'(mem[{pg, 8'(wr)}]));
        wr++;
      end else begin
        chk({tag, "_rd_page"}, 32'(DMA_ADDR[15:8]), 32'(pg));
        last_rd = DMA_ADDR;
      end
      if (rst_at == wr && DMA_RW_n && stall > 2) begin
        #2 RESET = 1'b1;
        #1 chk_idle({tag, "_async_rst"});
        step();
        chk_idle({tag, "_rst_hold"});
        RESET = 1'b0;
        ep = 1'b0;
        return;
      end
      if (gap == wr && DMA_RW_n && DMA_ADDR == {pg, 8'(wr)}) begin
        hold = DMA_ADDR;
        ENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          chk({tag, "_gap_addr"}, 32'(DMA_ADDR), 32'(hold));
          chk({tag, "_gap_rdy"}, 32'(CPU_RDY), 32'd0);
        end
        ENABLE = 1'b1;
      end
      step();
    end
    chk({tag, "_timeout"}, 32'(bound < 2000), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_writes"}, 32'(wr), 32'd256);
    chk({tag, "_last_rd"}, 32'(last_rd), {16'h0, pg, 8'hFF});
    chk_idle({tag, "_done"});
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h58;
    #1 chk_idle("reset");
    do_reset();
    chk_idle("post_reset");
    chk("ram_0200", 32'(mem[16'h0200]), 32'h5A);
    chk("ram_02ff", 32'(mem[16'h02FF]), 32'hA5);
    xfer("even", 8'h02, 1'b0, 513, -1, -1);
    xfer("odd", 8'h02, 1'b1, 514, -1, -1);
    xfer("wrap", 8'hFF, 1'b0, 513, -1, -1);
    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h02;
    step();
    chk_idle("rd_4014");
    CPU_ADDR = 16'h4015; CPU_RW_n = 1'b0;
    step();
    chk_idle("wr_4015");
    CPU_ADDR = 16'h2004;
    step();
    chk_idle("wr_2004");
    CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;
    step();
    chk_idle("quiet");
    xfer("gap_even", 8'h02, 1'b0, 513, 100, -1);
    xfer("gap_odd", 8'h02, 1'b1, 514, 100, -1);
    xfer("rst", 8'h02, 1'b0, 513, -1, 37);
    chk_idle("after_rst");
    xfer("p03", 8'h03, 1'b0, 513, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
